// File: rtl/wb_multicore_bridge_if.sv
// Bus bundle for wb_multicore_bridge: the upstream Caravel user-area slave bus
// plus the one-hot fan-out buses toward the neuron cores.
interface wb_multicore_bridge_if #(
    parameter int N_CORES = 4
);
    logic                   wbs_cyc_i;
    logic                   wbs_stb_i;
    logic                   wbs_we_i;
    logic [3:0]             wbs_sel_i;
    logic [31:0]            wbs_adr_i;
    logic [31:0]            wbs_dat_i;
    logic                   wbs_ack_o;
    logic [31:0]            wbs_dat_o;
    logic [N_CORES-1:0]     m_cyc_o;
    logic [N_CORES-1:0]     m_stb_o;
    logic                   m_we_o;
    logic [3:0]             m_sel_o;
    logic [31:0]            m_adr_o;
    logic [31:0]            m_dat_o;
    logic [N_CORES-1:0]     m_ack_i;
    logic [32*N_CORES-1:0]  m_dat_i;
    logic                   irq_o;

    // Bridge side.
    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o,
        output m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_adr_o, m_dat_o,
        input  m_ack_i, m_dat_i,
        output irq_o
    );

    // Host plus core-array side.
    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o,
        input  m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_adr_o, m_dat_o,
        output m_ack_i, m_dat_i,
        input  irq_o
    );
endinterface

// File: rtl/wb_multicore_bridge.sv
// Wishbone bridge fanning the Caravel user-area slave bus out to N_CORES neuron cores.
// Define BRIDGE_TIMEOUT_EN to enable the bus-hang timeout, sticky flag and irq_o.
module wb_multicore_bridge #(
    parameter int          N_CORES   = 4,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          TIMEOUT   = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    wb_multicore_bridge_if.slave  bus
);
    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;
    localparam logic [3:0]  N_IDX    = 4'(N_CORES);
    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT);
`ifdef BRIDGE_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_FWD, S_RESP} state_t;
    state_t r_state;
    state_t w_state_next;

    logic [31:0]        r_adr;
    logic [31:0]        r_dat;
    logic [31:0]        r_err_addr;
    logic [31:0]        r_dat_o;
    logic               r_we;
    logic               r_sticky;
    logic [3:0]         r_sel;
    logic [3:0]         r_idx;
    logic [15:0]        r_cnt;
    logic [N_CORES-1:0] r_mask;

    logic               w_hit;
    logic               w_is_local;
    logic               w_is_core;
    logic               w_core_en;
    logic               w_ack_sel;
    logic               w_timeout;
    logic               w_in_fwd;
    logic [3:0]         w_idx;
    logic [15:0]        w_mask16;
    logic [15:0]        w_ack16;
    logic [31:0]        w_be;
    logic [31:0]        w_local_rd;
    logic [31:0]        w_core_rd;
    logic [N_CORES-1:0] w_sel_core;
    logic [31:0]        w_slice [N_CORES];

    assign w_hit      = bus.wbs_cyc_i && bus.wbs_stb_i &&
                        (bus.wbs_adr_i[31:20] == BASE_ADDR[31:20]);
    assign w_idx      = bus.wbs_adr_i[19:16];
    assign w_is_local = (w_idx == 4'hF);
    assign w_is_core  = (w_idx < N_IDX);
    // Zero-extend to 16 so a 4-bit index never falls outside the vector.
    assign w_mask16   = 16'(r_mask);
    assign w_ack16    = 16'(bus.m_ack_i);
    assign w_core_en  = w_mask16[w_idx];
    assign w_ack_sel  = w_ack16[r_idx];
    assign w_timeout  = TO_EN && (r_cnt == TO_LIMIT);
    assign w_in_fwd   = (r_state == S_FWD);

    genvar gi;
    generate
        for (gi = 0; gi < N_CORES; gi++) begin : g_core
            assign w_sel_core[gi] = w_in_fwd && (r_idx == 4'(gi));
            assign w_slice[gi]    = (r_idx == 4'(gi)) ? bus.m_dat_i[32*gi +: 32] : 32'h0;
        end
        for (gi = 0; gi < 4; gi++) begin : g_be
            assign w_be[8*gi +: 8] = {8{bus.wbs_sel_i[gi]}};
        end
    endgenerate

    always_comb begin
        w_core_rd = 32'h0;
        for (int i = 0; i < N_CORES; i++) begin
            w_core_rd = w_core_rd | w_slice[i];
        end
    end

    always_comb begin
        w_local_rd = 32'h0;
        case (bus.wbs_adr_i[3:2])
            2'd0:    w_local_rd = {15'h0, r_sticky, 8'h0, 8'(N_CORES)};
            2'd1:    w_local_rd = r_err_addr;
            2'd2:    w_local_rd = 32'(r_mask);
            default: w_local_rd = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Abort outranks everything; a core ack outranks a coincident timeout.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_hit) begin
                    w_state_next = (w_is_core && w_core_en) ? S_FWD : S_RESP;
                end
            end
            S_FWD: begin
                if (!bus.wbs_cyc_i) begin
                    w_state_next = S_IDLE;
                end else if (w_ack_sel || w_timeout) begin
                    w_state_next = S_RESP;
                end
            end
            S_RESP:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_adr      <= 32'h0;
            r_dat      <= 32'h0;
            r_we       <= 1'b0;
            r_sel      <= 4'h0;
            r_idx      <= 4'h0;
            r_cnt      <= 16'h0;
            r_dat_o    <= 32'h0;
            r_err_addr <= 32'h0;
            r_sticky   <= 1'b0;
            r_mask     <= '1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_hit) begin
                        r_adr <= bus.wbs_adr_i;
                        r_dat <= bus.wbs_dat_i;
                        r_we  <= bus.wbs_we_i;
                        r_sel <= bus.wbs_sel_i;
                        r_idx <= w_idx;
                        r_cnt <= 16'h0;
                        if (w_is_local) begin
                            r_dat_o <= w_local_rd;
                            if (bus.wbs_we_i && (bus.wbs_adr_i[3:2] == 2'd0) &&
                                bus.wbs_sel_i[2] && bus.wbs_dat_i[16]) begin
                                r_sticky <= 1'b0;
                            end
                            if (bus.wbs_we_i && (bus.wbs_adr_i[3:2] == 2'd2)) begin
                                r_mask <= (r_mask & ~w_be[N_CORES-1:0]) |
                                          (bus.wbs_dat_i[N_CORES-1:0] & w_be[N_CORES-1:0]);
                            end
                        end else if (!(w_is_core && w_core_en)) begin
                            r_dat_o    <= ERR_DATA;
                            r_err_addr <= bus.wbs_adr_i;
                        end
                    end
                end
                S_FWD: begin
                    if (bus.wbs_cyc_i) begin
                        if (w_ack_sel) begin
                            r_dat_o <= w_core_rd;
                        end else if (w_timeout) begin
                            r_dat_o    <= ERR_DATA;
                            r_sticky   <= 1'b1;
                            r_err_addr <= r_adr;
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Shared core-side signals are gated so they are quiet outside a forward.
    assign bus.m_cyc_o   = w_sel_core;
    assign bus.m_stb_o   = w_sel_core;
    assign bus.m_we_o    = w_in_fwd && r_we;
    assign bus.m_sel_o   = w_in_fwd ? r_sel : 4'h0;
    assign bus.m_adr_o   = w_in_fwd ? {16'h0, r_adr[15:0]} : 32'h0;
    assign bus.m_dat_o   = w_in_fwd ? r_dat : 32'h0;
    assign bus.wbs_ack_o = (r_state == S_RESP);
    assign bus.wbs_dat_o = r_dat_o;
    assign bus.irq_o     = r_sticky;
endmodule

// File: tb/tb_wb_multicore_bridge.sv
// Scoreboard bench for wb_multicore_bridge: random and directed Wishbone traffic
// against a transaction-level model of decode, local registers and timeout.
module tb_wb_multicore_bridge;
    localparam int          NC       = 4;
    localparam int          TO       = 255;
    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;
`ifdef BRIDGE_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_multicore_bridge_if #(.N_CORES(NC)) bus ();

    wb_multicore_bridge #(
        .N_CORES  (NC),
        .BASE_ADDR(32'h3000_0000),
        .TIMEOUT  (TO)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [NC-1:0] m_mask   = '1;
    bit            m_sticky = 1'b0;
    logic [31:0]   m_err    = 32'h0;

    int          core_lat   [NC];
    bit          core_never [NC];
    logic [31:0] core_rdata [NC];
    int          core_cnt   [NC];

    typedef struct { bit chk; logic [31:0] data; } resp_t;
    typedef struct {
        logic [NC-1:0] stb; logic [31:0] adr; logic we; logic [3:0] sel; logic [31:0] dat;
    } fwd_t;
    resp_t resp_q [$];
    fwd_t  fwd_q  [$];

    task automatic fail_line(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_errors++;
        $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) fail_line(name, act, exp);
    endtask

    // Core models: ack L cycles after the strobe appears, plus noise acks on idle cores.
    initial begin
        logic [NC-1:0] ack_v;
        bus.m_ack_i = '0;
        bus.m_dat_i = '0;
        forever begin
            @(posedge clk); #1;
            for (int k = 0; k < NC; k++) begin
                if (bus.m_stb_o[k]) core_cnt[k]++; else core_cnt[k] = 0;
                ack_v[k] = bus.m_stb_o[k] && !core_never[k] && (core_cnt[k] == core_lat[k] + 1);
                bus.m_dat_i[32*k +: 32] = core_rdata[k];
            end
            bus.m_ack_i = ack_v | (NC'($urandom) & ~bus.m_stb_o);
        end
    end

    // Monitor: pops the scoreboards whenever the DUT acks or starts a forward.
    logic [NC-1:0] stb_prev = '0;
    always @(negedge clk) begin
        resp_t r;
        fwd_t  f;
        if (!rst_n) begin
            stb_prev = '0;
        end else begin
            if (bus.wbs_ack_o) begin
                if (resp_q.size() == 0) begin
                    n_checks++;
                    fail_line("unexpected_ack", bus.wbs_dat_o, 32'h0);
                end else begin
                    r = resp_q.pop_front();
                    if (r.chk) check_eq("read_data", bus.wbs_dat_o, r.data);
                end
            end
            if (bus.m_stb_o != '0 && stb_prev == '0) begin
                if (fwd_q.size() == 0) begin
                    n_checks++;
                    fail_line("unexpected_fwd", 32'(bus.m_stb_o), 32'h0);
                end else begin
                    f = fwd_q.pop_front();
                    check_eq("fwd_stb", 32'(bus.m_stb_o), 32'(f.stb));
                    check_eq("fwd_cyc", 32'(bus.m_cyc_o), 32'(f.stb));
                    check_eq("fwd_adr", bus.m_adr_o, f.adr);
                    check_eq("fwd_we",  32'(bus.m_we_o), 32'(f.we));
                    check_eq("fwd_sel", 32'(bus.m_sel_o), 32'(f.sel));
                    if (f.we) check_eq("fwd_dat", bus.m_dat_o, f.dat);
                end
            end
            stb_prev = bus.m_stb_o;
        end
    end

    task automatic drive_req(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                             input logic [3:0] sel);
        @(posedge clk); #1;
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_adr_i = adr;
        bus.wbs_we_i  = we;
        bus.wbs_dat_i = dat;
        bus.wbs_sel_i = sel;
    endtask

    task automatic release_req();
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
    endtask

    // One full transaction: predict, push expectations, drive, time the ack.
    task automatic txn(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                       input logic [3:0] sel);
        logic [3:0] idx;
        bit resp, got;
        int lat, n;
        logic [31:0] exp;
        resp_t r;
        fwd_t f;
        idx = adr[19:16];
        resp = 1'b0; lat = 0; exp = 32'h0;
        if (adr[31:20] == 12'h300) begin
            resp = 1'b1;
            if (idx == 4'hF) begin
                lat = 1;
                case (adr[3:2])
                    2'd0:    exp = (m_sticky ? 32'h0001_0000 : 32'h0) | 32'(NC);
                    2'd1:    exp = m_err;
                    2'd2:    exp = 32'(m_mask);
                    default: exp = 32'h0;
                endcase
                if (we && adr[3:2] == 2'd0 && sel[2] && dat[16]) m_sticky = 1'b0;
                if (we && adr[3:2] == 2'd2 && sel[0]) m_mask = dat[NC-1:0];
            end else if (int'(idx) < NC && m_mask[idx[1:0]]) begin
                f.stb = NC'(1) << idx[1:0];
                f.adr = {16'h0, adr[15:0]};
                f.we = we; f.sel = sel; f.dat = dat;
                fwd_q.push_back(f);
                if (TO_EN && (core_never[idx[1:0]] || core_lat[idx[1:0]] > TO)) begin
                    lat = TO + 2; exp = ERR_DATA; m_sticky = 1'b1; m_err = adr;
                end else begin
                    lat = 2 + core_lat[idx[1:0]]; exp = core_rdata[idx[1:0]];
                end
            end else begin
                lat = 1; exp = ERR_DATA; m_err = adr;
            end
            r.chk = !we; r.data = exp;
            resp_q.push_back(r);
        end
        drive_req(adr, we, dat, sel);
        n = 0; got = 1'b0;
        while (!got && n < (resp ? lat + 4 : 6)) begin
            @(posedge clk); #1;
            n++;
            if (bus.wbs_ack_o) got = 1'b1;
        end
        release_req();
        if (resp) begin
            check_eq("ack_seen", 32'(got), 32'd1);
            if (got) check_eq("ack_latency", 32'(n), 32'(lat));
        end else begin
            check_eq("miss_no_ack", 32'(got), 32'd0);
            check_eq("miss_no_stb", 32'(bus.m_stb_o), 32'h0);
        end
        check_eq("irq", 32'(bus.irq_o), 32'(m_sticky));
    endtask

    // Start a forward to a core that will never ack; returns with m_stb_o up.
    task automatic start_fwd(input logic [31:0] adr, input logic we, input logic [31:0] dat);
        fwd_t f;
        int n;
        f.stb = NC'(1) << adr[17:16];
        f.adr = {16'h0, adr[15:0]};
        f.we = we; f.sel = 4'hF; f.dat = dat;
        fwd_q.push_back(f);
        drive_req(adr, we, dat, 4'hF);
        n = 0;
        while (bus.m_stb_o == '0 && n < 5) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("fwd_started", 32'(bus.m_stb_o != '0), 32'd1);
    endtask

    task automatic check_outputs_zero();
        check_eq("rst_wbs_ack", 32'(bus.wbs_ack_o), 32'h0);
        check_eq("rst_wbs_dat", bus.wbs_dat_o, 32'h0);
        check_eq("rst_m_cyc", 32'(bus.m_cyc_o), 32'h0);
        check_eq("rst_m_stb", 32'(bus.m_stb_o), 32'h0);
        check_eq("rst_m_we", 32'(bus.m_we_o), 32'h0);
        check_eq("rst_m_sel", 32'(bus.m_sel_o), 32'h0);
        check_eq("rst_m_adr", bus.m_adr_o, 32'h0);
        check_eq("rst_m_dat", bus.m_dat_o, 32'h0);
        check_eq("rst_irq", 32'(bus.irq_o), 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0]  idx;
        logic [31:0] adr;
        int          kind;
        release_req();
        bus.wbs_adr_i = 32'h0; bus.wbs_dat_i = 32'h0; bus.wbs_sel_i = 4'h0;
        for (int k = 0; k < NC; k++) begin
            core_lat[k] = 1; core_never[k] = 1'b0; core_rdata[k] = 32'h0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Reset values of the local registers
        txn(32'h300F_0000, 1'b0, 32'h0, 4'hF);
        txn(32'h300F_0004, 1'b0, 32'h0, 4'hF);
        txn(32'h300F_0008, 1'b0, 32'h0, 4'hF);

        // Core 2 read, one-cycle core latency
        core_rdata[2] = 32'h1234_5678; core_lat[2] = 1;
        txn(32'h3002_0010, 1'b0, 32'h0, 4'hF);

        // Disable core 1, then hit it
        txn(32'h300F_0008, 1'b1, 32'h0000_000D, 4'hF);
        txn(32'h3001_0000, 1'b0, 32'h0, 4'hF);
        txn(32'h300F_0004, 1'b0, 32'h0, 4'hF);
        txn(32'h300F_0008, 1'b1, 32'h0000_000F, 4'hF);

`ifdef BRIDGE_TIMEOUT_EN
        core_never[0] = 1'b1;
        txn(32'h3000_0000, 1'b0, 32'h0, 4'hF);
        core_never[0] = 1'b0;
        txn(32'h300F_0000, 1'b0, 32'h0, 4'hF);
        txn(32'h300F_0004, 1'b0, 32'h0, 4'hF);
        txn(32'h300F_0000, 1'b1, 32'h0001_0000, 4'hF);
        txn(32'h300F_0000, 1'b0, 32'h0, 4'hF);
`endif

        // Core ack lands in the same cycle the timeout would fire
        core_lat[3] = TO; core_rdata[3] = 32'hCAFE_F00D;
        txn(32'h3003_0000, 1'b0, 32'h0, 4'hF);
        txn(32'h300F_0000, 1'b0, 32'h0, 4'hF);
        core_lat[3] = 1;

        // Abort during forward
        core_never[0] = 1'b1;
        start_fwd(32'h3000_0040, 1'b0, 32'h0);
        repeat (2) begin @(posedge clk); #1; end
        release_req();
        @(posedge clk); #1;
        check_eq("abort_m_cyc", 32'(bus.m_cyc_o), 32'h0);
        check_eq("abort_m_stb", 32'(bus.m_stb_o), 32'h0);
        repeat (3) begin
            @(posedge clk); #1;
            check_eq("abort_no_ack", 32'(bus.wbs_ack_o), 32'h0);
        end
        core_never[0] = 1'b0;

        // Misses
        txn(32'h4000_0000, 1'b0, 32'h0, 4'hF);
        txn(32'h3010_0000, 1'b1, 32'h5555_AAAA, 4'hF);

        // Randomized traffic
        for (int i = 0; i < 80; i++) begin
            kind = $urandom_range(0, 11);
            if (kind <= 5) begin
                idx = 4'(kind % NC);
                core_rdata[idx[1:0]] = $urandom;
                core_lat[idx[1:0]] = $urandom_range(1, 6);
            end else if (kind <= 7) begin
                idx = 4'($urandom_range(NC, 14));
            end else begin
                idx = 4'hF;
            end
            adr = {12'h300, idx, 16'($urandom)};
            if (kind == 10) adr = {12'h400 | 12'($urandom_range(0, 255)), 20'($urandom)};
            if (kind == 11) txn({12'h300, 4'hF, 16'h0008}, 1'b1, $urandom, 4'hF);
            else txn(adr, 1'($urandom), $urandom, 4'($urandom));
        end

        // Reset in the middle of a forward
        txn(32'h300F_0008, 1'b1, 32'h0000_000F, 4'hF);
        core_never[1] = 1'b1;
        start_fwd(32'h3001_0024, 1'b1, 32'hA5A5_0001);
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_outputs_zero();
        release_req();
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_mask = '1; m_sticky = 1'b0; m_err = 32'h0;
        core_never[1] = 1'b0;
        txn(32'h300F_0008, 1'b0, 32'h0, 4'hF);
        txn(32'h300F_0000, 1'b0, 32'h0, 4'hF);
        txn(32'h300F_0004, 1'b0, 32'h0, 4'hF);

        repeat (3) @(posedge clk);
        check_eq("resp_q_drained", 32'(resp_q.size()), 32'h0);
        check_eq("fwd_q_drained", 32'(fwd_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
